ans_stream_encoder: RTL

ANS_STREAM_ENCODER -- requirements
Module: ans_stream_encoder

---
 rtl/ans_stream_encoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ans_stream_encoder.sv
// Streaming rANS encoder: one symbol per IDLE->RENORM->ENCODE pass, renormalising
// the coder state out in SYM_WIDTH chunks and flushing the full state on in_last.
module ans_stream_encoder #(
    parameter int SYM_WIDTH   = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int STATE_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ena,
    input  logic [CNT_WIDTH-1:0]           s_count,
    input  logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
    input  logic [STATE_WIDTH-1:0]         total_count,
    input  logic                           in_last,
    input  logic                           in_vld,
    output logic                           in_rdy,
    output logic [SYM_WIDTH-1:0]           out,
    output logic                           out_last,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic                           err
);

    localparam int NUM_CHUNKS = STATE_WIDTH / SYM_WIDTH;
    localparam int CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int THR_W      = STATE_WIDTH + CNT_WIDTH + SYM_WIDTH;
    localparam int PROD_W     = 2 * STATE_WIDTH;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENORM = 2'd1,
        ENCODE = 2'd2,
        FLUSH  = 2'd3
    } fsm_t;

    fsm_t                           fsm_q, fsm_d;
    logic [STATE_WIDTH-1:0]         state_q, state_d;
    logic [CHUNK_W-1:0]             chunk_q, chunk_d;
    logic [CNT_WIDTH-1:0]           cnt_q;
    logic [SYM_WIDTH+CNT_WIDTH-1:0] cum_q;
    logic                           last_q;

    logic [THR_W-1:0]       renorm_thr;
    logic                   need_chunk;
    logic [CNT_WIDTH-1:0]   cnt_nz;
    logic [PROD_W-1:0]      div_q, div_r;
    logic [STATE_WIDTH-1:0] enc_state;

    // Threshold kept wide so count << SYM_WIDTH never wraps.
    assign renorm_thr = THR_W'(cnt_q) << SYM_WIDTH;
    assign need_chunk = THR_W'(state_q) >= renorm_thr;

    // Divisor forced nonzero so the unused ENCODE datapath stays defined on illegal symbols.
    assign cnt_nz    = (cnt_q == '0) ? CNT_WIDTH'(1) : cnt_q;
    assign div_q     = PROD_W'(state_q) / PROD_W'(cnt_nz);
    assign div_r     = PROD_W'(state_q) % PROD_W'(cnt_nz);
    assign enc_state = STATE_WIDTH'(div_q * PROD_W'(total_count) + PROD_W'(cum_q) + div_r);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= total_count;
            chunk_q <= '0;
            cnt_q   <= '0;
            cum_q   <= '0;
            last_q  <= 1'b0;
        end else if (ena) begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            chunk_q <= chunk_d;
            if (fsm_q == IDLE && in_vld) begin
                cnt_q  <= s_count;
                cum_q  <= s_cumulative;
                last_q <= in_last;
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        chunk_d = chunk_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_vld) fsm_d = RENORM;
            end
            RENORM: begin
                if (cnt_q == '0) begin
                    fsm_d = IDLE;
                end else if (need_chunk) begin
                    if (out_rdy) state_d = state_q >> SYM_WIDTH;
                end else begin
                    fsm_d = ENCODE;
                end
            end
            ENCODE: begin
                state_d = enc_state;
                fsm_d   = last_q ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (out_rdy) begin
                    if (chunk_q == LAST_CHUNK) begin
                        state_d = total_count;
                        chunk_d = '0;
                        fsm_d   = IDLE;
                    end else begin
                        state_d = state_q >> SYM_WIDTH;
                        chunk_d = chunk_q + CHUNK_W'(1);
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs decode registered state; err alone is qualified by ena so a stalled
    // illegal-symbol cycle does not report the error more than once.
    always_comb begin
        in_rdy   = (fsm_q == IDLE);
        out      = state_q[SYM_WIDTH-1:0];
        out_vld  = 1'b0;
        out_last = 1'b0;
        err      = 1'b0;
        if (fsm_q == RENORM) begin
            out_vld = (cnt_q != '0) && need_chunk;
            err     = (cnt_q == '0) && ena;
        end else if (fsm_q == FLUSH) begin
            out_vld  = 1'b1;
            out_last = (chunk_q == LAST_CHUNK);
        end
    end

endmodule
